alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have, for each requester i in {0,1}, port reqi_valid  input  1  requester i presents an operation.
REQ-005 The block SHALL have port reqi_ready  output  1  the block accepts requester i's operation this cycle.
REQ-006 The block SHALL have port reqi_op  input  3  the ALU opcode: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT (signed), 100 SLL, 101 SRL.
REQ-007 The block SHALL have ports reqi_a and reqi_b  input  WIDTH  the operands, and reqi_shamt  input  5  the shift amount.
REQ-008 The block SHALL have port rspi_valid  output  1  a result for requester i is held.
REQ-009 The block SHALL have port rspi_ready  input  1  requester i takes the result.
REQ-010 The block SHALL have ports rspi_y  output  WIDTH  the result, rspi_zero  output  1  (y==0), and rspi_err  output  1  the opcode was unsupported.

Function
REQ-011 The block SHALL time-share one internal ALU between the two requesters and have exactly one transaction in flight at a time.
REQ-012 The FSM SHALL have two states: IDLE and RESP.
REQ-013 In IDLE, at most one reqi_ready SHALL be high.
  - Grant goes to the only valid requester.
  - If both requesters are valid, grant goes to the requester not granted last (round-robin).
  - With no requester valid, both readies are low.
REQ-014 reqi_ready SHALL be low in RESP.
REQ-015 On a rising edge with reqi_valid && reqi_ready, the block SHALL:
  - capture op, a, b and shamt;
  - record grant owner i;
  - update last_grant to i;
  - move to RESP.
REQ-016 In RESP, rsp{owner}_valid SHALL be high and the other rsp_valid low.
  - Result is available the cycle after the accept edge (latency 1).
REQ-017 rspi_y SHALL be computed from the captured operands only.
  - Shifts use b as the shifted value: SLL gives b<<shamt, SRL gives b>>shamt (logical).
  - SLT gives 1 if a<b as signed values, else 0.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-018 Unsupported opcode 011 SHALL produce y=0, zero=1, err=1.
  - err SHALL be 0 for all supported opcodes.
REQ-019 rspi_y, rspi_zero and rspi_err SHALL remain stable while rspi_valid is high and rspi_ready is low; backpressure has no limit.
REQ-020 On a rising edge in RESP with rsp{owner}_ready high, the FSM SHALL return to IDLE.
  - A new request is accepted no earlier than the following edge (minimum 2 cycles per transaction).
REQ-021 Changes on the requester inputs while in RESP SHALL NOT affect the held result.
REQ-022 rspi_ready asserted while rspi_valid is low SHALL have no effect.
REQ-023 When rspi_valid is low, rspi_y, rspi_zero and rspi_err SHALL be 0.

Reset
REQ-024 While rst_n is low, the block SHALL be in IDLE and all reqi_ready and rspi_valid SHALL be 0.
REQ-025 While rst_n is low, captured operand registers SHALL be 0 and last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-026 Reset assertion SHALL take effect immediately, independent of clk, including mid-RESP.
  - Any held result is discarded without a handshake.
REQ-027 After rst_n deasserts, the block SHALL accept a request on the first rising edge where one is valid.

Verification
REQ-028 Single request: req0 ADD a=5 b=7 -> req0_ready high in IDLE; next cycle rsp0_valid=1, rsp0_y=12, zero=0, err=0; rsp1_valid=0.
REQ-029 Tie after reset: req0 AND a=0xF0 b=0x3C and req1 OR a=0xF0 b=0x0F, both valid and held, rsp_ready=1 ->
  - req0 served first: rsp0_y=0x30.
  - then req1: rsp1_y=0xFF.
  - then req0 again if still valid.
REQ-030 Zero and signed compare:
  - SUB a=3 b=3 -> y=0, zero=1.
  - SLT a=0xFFFFFFFF b=1 -> y=1.
  - SRL b=0x80000000 shamt=31 -> y=1.
  - SLL b=1 shamt=4 -> y=0x10.
REQ-031 Backpressure: req1 ADD a=0xFFFFFFFF b=1, rsp1_ready low 3 cycles while req inputs change ->
  - rsp1_y=0, zero=1 held stable.
  - both reqi_ready remain 0.
  - IDLE resumes the edge after rsp1_ready rises.
REQ-032 Unsupported op 011 from req0 -> rsp0_y=0, zero=1, err=1.
REQ-033 Reset mid-RESP: rst_n low asynchronously between edges ->
  - rsp_valid drops without a clock edge.
  - after release, a tie grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters time-share one ALU with round-robin grant.
// Only one transaction is in flight at a time. The accepted operands are
// captured into registers. The result is held for the owning requester
// until that requester takes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state, state_next;
  logic             owner, last_grant;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       shamt_q;
  logic             grant_valid, grant_id, rsp_take;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err, alu_zero;

  // In IDLE pick one valid requester, alternating on a tie
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  // State register; reset drops any held result immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: accept moves to RESP, the owner's take returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = RESP;
      RESP:    if (rsp_take)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted operands and remember who owns the transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shamt_q    <= '0;
    end else if (grant_valid) begin
      owner      <= grant_id;
      last_grant <= grant_id;
      op_q       <= grant_id ? req1_op    : req0_op;
      a_q        <= grant_id ? req1_a     : req0_a;
      b_q        <= grant_id ? req1_b     : req0_b;
      shamt_q    <= grant_id ? req1_shamt : req0_shamt;
    end
  end

  // Shared ALU working only from the captured operands
  always_comb begin
    alu_y   = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  alu_y = b_q << shamt_q;
      OP_SRL:  alu_y = b_q >> shamt_q;
      default: alu_err = 1'b1;
    endcase
    alu_zero = (alu_y == '0);
  end

  // Outputs: only the owner sees a result in RESP, everything else is zero
  always_comb begin
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    rsp0_y     = rsp0_valid ? alu_y : '0;
    rsp1_y     = rsp1_valid ? alu_y : '0;
    rsp0_zero  = rsp0_valid && alu_zero;
    rsp1_zero  = rsp1_valid && alu_zero;
    rsp0_err   = rsp0_valid && alu_err;
    rsp1_err   = rsp1_valid && alu_err;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for
// alu_arbiter. A transaction-level reference model predicts every output.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [2:0]    req_op [2];
  logic [W-1:0]  req_a [2];
  logic [W-1:0]  req_b [2];
  logic [4:0]    req_shamt [2];
  logic [W-1:0]  rsp_y [2];

  int errors = 0;
  int checks = 0;

  // Model state: the pending result, its owner and the round-robin history
  bit           m_held;
  bit           m_owner;
  bit           m_last;
  logic [W-1:0] m_y;
  bit           m_err;
  bit           p_grant_valid;
  bit           p_grant;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_shamt(req_shamt[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_y(rsp_y[0]),
    .rsp0_zero(rsp_zero[0]), .rsp0_err(rsp_err[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_shamt(req_shamt[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_y(rsp_y[1]),
    .rsp1_zero(rsp_zero[1]), .rsp1_err(rsp_err[1])
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference ALU from the opcode table, using plain arithmetic
  function automatic logic [W:0] refAlu(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [4:0] sh);
    longint unsigned scale;
    longint unsigned wide;
    int sa;
    int sb;
    scale = 64'd1 << sh;
    sa = a;
    sb = b;
    case (op)
      3'b010: return {1'b0, a + b};
      3'b110: return {1'b0, a - b};
      3'b000: return {1'b0, a & b};
      3'b001: return {1'b0, a | b};
      3'b111: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
      3'b100: begin wide = b * scale; return {1'b0, wide[W-1:0]}; end
      3'b101: begin wide = b / scale; return {1'b0, wide[W-1:0]}; end
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic modelReset();
    m_held = 0;
    m_owner = 0;
    m_last = 1;
    m_y = '0;
    m_err = 0;
  endtask

  task automatic setOperands(input int i, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [4:0] sh);
    req_op[i] = op;
    req_a[i] = a;
    req_b[i] = b;
    req_shamt[i] = sh;
  endtask

  // Compare every output with what the model predicts for this cycle
  task automatic compareModel();
    p_grant_valid = 0;
    p_grant = 0;
    if (!m_held) begin
      if (req_valid == 2'b11) begin
        p_grant_valid = 1;
        p_grant = !m_last;
      end else if (req_valid[0]) begin
        p_grant_valid = 1;
      end else if (req_valid[1]) begin
        p_grant_valid = 1;
        p_grant = 1;
      end
    end
    checkOutput("req0_ready", {31'd0, req_ready[0]}, {31'd0, p_grant_valid && !p_grant});
    checkOutput("req1_ready", {31'd0, req_ready[1]}, {31'd0, p_grant_valid && p_grant});
    for (int i = 0; i < 2; i++) begin
      bit mine;
      mine = m_held && (m_owner == i[0]);
      checkOutput($sformatf("rsp%0d_valid", i), {31'd0, rsp_valid[i]}, {31'd0, mine});
      checkOutput($sformatf("rsp%0d_y", i), rsp_y[i], mine ? m_y : '0);
      checkOutput($sformatf("rsp%0d_zero", i), {31'd0, rsp_zero[i]}, {31'd0, mine && (m_y == 0)});
      checkOutput($sformatf("rsp%0d_err", i), {31'd0, rsp_err[i]}, {31'd0, mine && m_err});
    end
  endtask

  // Drive handshakes at the falling edge, then check once logic settles
  task automatic applyStimulus(input bit v0, input bit v1, input bit r0, input bit r1);
    req_valid = {v1, v0};
    rsp_ready = {r1, r0};
    #1;
    compareModel();
  endtask

  // Advance the model across the rising edge, then return to the falling edge
  task automatic endCycle();
    logic [W:0] r;
    @(posedge clk);
    if (m_held) begin
      if (rsp_ready[m_owner]) m_held = 0;
    end else if (p_grant_valid) begin
      r = refAlu(req_op[p_grant], req_a[p_grant], req_b[p_grant], req_shamt[p_grant]);
      m_held = 1;
      m_owner = p_grant;
      m_last = p_grant;
      m_y = r[W-1:0];
      m_err = r[W];
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 0;
    #1;
    checkOutput("reset_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Single req0 transaction with an explicit expected result
  task automatic singleOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh,
                          input logic [W-1:0] ey, input bit ez, input bit ee);
    setOperands(0, op, a, b, sh);
    applyStimulus(1, 0, 1, 1);
    checkOutput({tag, "_accept"}, {31'd0, req_ready[0]}, 32'd1);
    endCycle();
    applyStimulus(0, 0, 1, 1);
    checkOutput({tag, "_y"}, rsp_y[0], ey);
    checkOutput({tag, "_zero"}, {31'd0, rsp_zero[0]}, {31'd0, ez});
    checkOutput({tag, "_err"}, {31'd0, rsp_err[0]}, {31'd0, ee});
    endCycle();
  endtask

  initial begin
    rst_n = 0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < 2; i++) setOperands(i, 3'b000, '0, '0, '0);
    modelReset();
    @(negedge clk);
    doReset();

    // Single ADD from req0 with one cycle latency
    setOperands(0, 3'b010, 32'd5, 32'd7, 5'd0);
    applyStimulus(1, 0, 1, 1);
    checkOutput("add_ready0", {31'd0, req_ready[0]}, 32'd1);
    endCycle();
    applyStimulus(0, 0, 1, 1);
    checkOutput("add_valid0", {31'd0, rsp_valid[0]}, 32'd1);
    checkOutput("add_y", rsp_y[0], 32'd12);
    checkOutput("add_valid1", {31'd0, rsp_valid[1]}, 32'd0);
    endCycle();

    // Tie after reset alternates 0, 1, 0
    doReset();
    setOperands(0, 3'b000, 32'hF0, 32'h3C, 5'd0);
    setOperands(1, 3'b001, 32'hF0, 32'h0F, 5'd0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("tie_first", {30'd0, req_ready}, 32'd1);
    endCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("tie_y0", rsp_y[0], 32'h30);
    endCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("tie_second", {30'd0, req_ready}, 32'd2);
    endCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("tie_y1", rsp_y[1], 32'hFF);
    endCycle();
    applyStimulus(1, 1, 1, 1);
    checkOutput("tie_third", {30'd0, req_ready}, 32'd1);
    endCycle();
    applyStimulus(0, 0, 1, 1);
    endCycle();

    // Zero flag, signed compare, shifts and the unsupported opcode
    singleOp("sub_zero", 3'b110, 32'd3, 32'd3, 5'd0, 32'd0, 1, 0);
    singleOp("slt_neg", 3'b111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 0, 0);
    singleOp("srl_31", 3'b101, 32'h0, 32'h80000000, 5'd31, 32'd1, 0, 0);
    singleOp("sll_4", 3'b100, 32'h0, 32'd1, 5'd4, 32'h10, 0, 0);
    singleOp("bad_op", 3'b011, 32'd9, 32'd9, 5'd3, 32'd0, 1, 1);

    // Backpressure on req1 while request inputs keep changing
    setOperands(1, 3'b010, 32'hFFFFFFFF, 32'd1, 5'd0);
    applyStimulus(0, 1, 0, 0);
    endCycle();
    for (int k = 0; k < 3; k++) begin
      setOperands(0, 3'($urandom), $urandom, $urandom, 5'($urandom));
      setOperands(1, 3'($urandom), $urandom, $urandom, 5'($urandom));
      applyStimulus(1, 1, 1, 0);
      checkOutput("bp_y", rsp_y[1], 32'd0);
      checkOutput("bp_zero", {31'd0, rsp_zero[1]}, 32'd1);
      checkOutput("bp_ready", {30'd0, req_ready}, 32'd0);
      endCycle();
    end
    applyStimulus(1, 0, 0, 1);
    checkOutput("bp_release_held", {31'd0, rsp_valid[1]}, 32'd1);
    endCycle();
    applyStimulus(1, 0, 1, 1);
    checkOutput("bp_idle_again", {30'd0, req_ready}, 32'd1);
    endCycle();
    applyStimulus(0, 0, 1, 1);
    endCycle();

    // Asynchronous reset in the middle of RESP
    setOperands(0, 3'b010, 32'd1, 32'd2, 5'd0);
    applyStimulus(1, 0, 0, 0);
    endCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("mid_held", {31'd0, rsp_valid[0]}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    checkOutput("mid_async_drop", {30'd0, rsp_valid}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
    applyStimulus(1, 1, 1, 1);
    checkOutput("mid_tie_req0", {30'd0, req_ready}, 32'd1);
    endCycle();

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
        b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
        setOperands(i, 3'($urandom_range(0, 7)), a, b, 5'($urandom));
      end
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      endCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
